tx_symbol_mux_ml: RTL and testbench
===================================

# tx_symbol_mux_ml

Multi-lane, parametrised successor to the single-byte forced-control symbol mux in the PHY transmit path. Each cycle it drives one registered symbol per lane, chosen from three sources: a buffered data stream, a handshaked control-symbol request, or an automatically inserted SKP ordered set. It also flags K-characters per lane and holds a sticky link VALID. It sits between the TX buffer and the 8b/10b encoder.

## Interface
Parameters:
- LANES, 1: number of byte lanes, 1..4.
- DEPTH, 4: data FIFO entries, power of two, at least 2.
- SKP_INTERVAL, 1180: cycles between SKP ordered-set insertions, at least SKP_COUNT+2.
- SKP_COUNT, 3: SKP symbols following the COM, 1..5.

Ports:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- DATA_IN  in  8*LANES  data word; lane n is bits [8n+7:8n].
- DATA_PUSH  in  1  write DATA_IN into the FIFO.
- FIFO_FULL  out  1  FIFO holds DEPTH entries.
- FIFO_EMPTY  out  1  FIFO holds 0 entries.
- OVERFLOW  out  1  sticky; set when a push is dropped.
- CTRL_REQ  in  1  control-symbol request; level, held until ACK.
- CTRL_SEL  in  4  0 COM, 1 PAD, 2 SKP, 3 STP, 4 SDP, 5 END, 6 EDB, 7 FTS, 8 IDL.
- CTRL_ACK  out  1  one-cycle pulse; the request was consumed.
- CTRL_ERR  out  1  one-cycle pulse with ACK when CTRL_SEL > 8.
- OUT  out  8*LANES  registered symbols.
- K_OUT  out  LANES  per-lane K-character flag.
- VALID  out  1  sticky; rises on the edge the first COM is registered onto OUT.

## Operation
- FSM states: IDLE, DATA, CTRL, SKP_COM, SKP_SYM. Every state lasts one cycle except SKP_SYM, which lasts SKP_COUNT cycles.
- Decision order each cycle, outside an ordered set:
  1. skp_due
  2. CTRL_REQ
  3. FIFO non-empty
  4. idle
- Idle output: IDL on every lane, K_OUT all ones.
- CTRL: the selected symbol is replicated on all lanes, K_OUT all ones, and ACK pulses on the same edge. For CTRL_SEL > 8 the output is IDL, and ACK and ERR both pulse.
- DATA: the FIFO head is popped onto OUT with K_OUT = 0.
- SKP ordered set:
  - Timing: COM on all lanes for 1 cycle, then SKP on all lanes for SKP_COUNT cycles. K_OUT is all ones throughout.
  - The set is never interrupted. CTRL_REQ and data wait; the request stays pending with no ACK.
- Skip counter:
  - Free-runs from 0 and sets skp_due when it reaches SKP_INTERVAL-1.
  - Clears on entry to SKP_COM.
  - Saturates while skp_due is waiting, which happens only for an ordered set already in progress.
- FIFO:
  - A push while full is dropped and sets OVERFLOW.
  - A push and a pop in the same cycle while full are both accepted.
  - A push into an empty FIFO is poppable the next cycle, never the same cycle.
- VALID: set by any COM output, whether from CTRL_SEL=0 or from SKP_COM. Cleared only by RESET.

## Timing
- All outputs are registered. A decision made in cycle t appears on OUT at edge t+1.
- Worst-case wait before a pending CTRL_REQ is ACKed is SKP_COUNT+1 cycles.
- RESET values:
  - OUT = 0, K_OUT = 0, VALID = 0.
  - CTRL_ACK = 0, CTRL_ERR = 0.
  - OVERFLOW = 0, FIFO_EMPTY = 1, FIFO_FULL = 0.
  - FIFO pointers cleared, counter = 0, state IDLE.
- RESET mid-ordered-set aborts the set immediately. The next cycle follows the normal decision order.
- Wrap-around: FIFO pointers carry one extra bit to distinguish full from empty. The counter wraps only through the clear on entry to SKP_COM.

## Configuration
- SKP_INSERT_EN defined: periodic SKP ordered sets as described above.
- SKP_INSERT_EN undefined:
  - The counter, skp_due and the SKP_COM/SKP_SYM states are compiled out.
  - SKP is emitted only via CTRL_SEL=2. VALID then rises only on CTRL_SEL=0.
  - SKP_INTERVAL and SKP_COUNT are ignored.

## Structure
- Shared package tx_sym_pkg holds:
  - symbol constants: COM 8'hBC, PAD 8'hF7, SKP 8'h1C, STP 8'hFB, SDP 8'h5C, END 8'hFD, EDB 8'hFE, FTS 8'h3C, IDL 8'h7C;
  - CTRL_SEL codes;
  - the FSM state encoding.
- Sub-module tx_sym_fifo: synchronous FIFO, width 8*LANES, depth DEPTH, with full, empty and overflow outputs.

## Test plan
- Reset with LANES=2, then idle for 3 cycles -> OUT = 16'h7C7C, K_OUT = 2'b11, VALID = 0.
- CTRL_REQ with CTRL_SEL=0 -> next edge OUT = 16'hBCBC, ACK pulses, and VALID = 1 on that same edge and stays high.
- Push 5 words 16'h0100..16'h0104 with DEPTH=4 and no pops (CTRL_REQ held) -> FIFO_FULL = 1, OVERFLOW = 1. After release, OUT shows 0100..0103 in order with K_OUT = 0.
- SKP_INSERT_EN, SKP_INTERVAL=10, SKP_COUNT=3, continuous data:
  - every 10 cycles OUT shows BC, 1C, 1C, 1C;
  - data stalls during the set and resumes with no loss.
- CTRL_REQ raised during SKP_SYM -> ACK only after the last SKP; CTRL_SEL=12 -> OUT IDL, and ACK and ERR pulse together.
- RESET asserted during SKP_SYM -> all outputs at reset values next edge; a queued request is served afterwards.

Source files
------------

// File: rtl/tx_sym_pkg.sv
// ----------------------------------------------------------------------------
// tx_sym_pkg
//   Shared definitions for the multi-lane TX symbol mux: 8b/10b control symbol
//   byte values, CTRL_SEL request codes, the mux FSM state encoding, and a
//   helper that maps a request code onto its control symbol.
// ----------------------------------------------------------------------------
package tx_sym_pkg;

    // Control symbol byte values (K-characters once encoded).
    localparam logic [7:0] SymCom = 8'hBC;
    localparam logic [7:0] SymPad = 8'hF7;
    localparam logic [7:0] SymSkp = 8'h1C;
    localparam logic [7:0] SymStp = 8'hFB;
    localparam logic [7:0] SymSdp = 8'h5C;
    localparam logic [7:0] SymEnd = 8'hFD;
    localparam logic [7:0] SymEdb = 8'hFE;
    localparam logic [7:0] SymFts = 8'h3C;
    localparam logic [7:0] SymIdl = 8'h7C;

    // CTRL_SEL request codes; anything above SelIdl is an error request.
    typedef enum logic [3:0] {
        SelCom = 4'd0,
        SelPad = 4'd1,
        SelSkp = 4'd2,
        SelStp = 4'd3,
        SelSdp = 4'd4,
        SelEnd = 4'd5,
        SelEdb = 4'd6,
        SelFts = 4'd7,
        SelIdl = 4'd8
    } ctrl_sel_e;

    localparam logic [3:0] SelMax = 4'd8;

    // Mux FSM states. The SKP states are only reachable with SKP insertion on.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StData   = 3'd1,
        StCtrl   = 3'd2,
        StSkpCom = 3'd3,
        StSkpSym = 3'd4
    } state_e;

    // Map a request code to its symbol; illegal codes fall back to IDL.
    function automatic logic [7:0] ctrl_symbol(input logic [3:0] sel);
        logic [7:0] sym;
        case (sel)
            SelCom:  sym = SymCom;
            SelPad:  sym = SymPad;
            SelSkp:  sym = SymSkp;
            SelStp:  sym = SymStp;
            SelSdp:  sym = SymSdp;
            SelEnd:  sym = SymEnd;
            SelEdb:  sym = SymEdb;
            SelFts:  sym = SymFts;
            default: sym = SymIdl;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tx_sym_fifo.sv
// ----------------------------------------------------------------------------
// tx_sym_fifo
//   Synchronous FIFO holding data words for the TX symbol mux.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//   A push while full is dropped (sticky overflow) unless a pop happens in the
//   same cycle, in which case both are accepted. Read data is the current head
//   and is only valid while not empty; a pushed word becomes visible at the
//   head on the following cycle.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   push_i      write wdata_i
//   wdata_i     write data
//   pop_i       remove the head entry
//   rdata_o     head entry
//   full_o      DEPTH entries held
//   empty_o     no entries held
//   overflow_o  sticky, set when a push is dropped
// ----------------------------------------------------------------------------
module tx_sym_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop_ok  = pop_i && !empty_o;
    // A simultaneous pop frees the slot the push needs.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_ok};
        overflow_d = overflow_q | (push_i & ~push_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o    = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o = overflow_q;

endmodule

// File: rtl/tx_symbol_mux_ml.sv
// ----------------------------------------------------------------------------
// tx_symbol_mux_ml
//   Multi-lane TX symbol mux between the TX buffer and the 8b/10b encoder.
//   Each cycle one registered symbol per lane is chosen from (highest first):
//   a due/in-progress SKP ordered set, a handshaked control request, buffered
//   data, or IDL. Control symbols are replicated across all lanes.
//
//   Build option SKP_INSERT_EN: when defined, a COM followed by SKP_COUNT SKP
//   symbols is inserted every SKP_INTERVAL cycles. When undefined, the skip
//   counter and SKP states are compiled out and SKP is only sent on request.
//
// Ports:
//   CLK         clock, rising edge
//   RESET       synchronous active-high reset
//   DATA_IN     data word, lane n on bits [8n+7:8n]
//   DATA_PUSH   write DATA_IN into the FIFO
//   FIFO_FULL   FIFO holds DEPTH entries
//   FIFO_EMPTY  FIFO holds no entries
//   OVERFLOW    sticky, a push was dropped
//   CTRL_REQ    control request, level held until CTRL_ACK
//   CTRL_SEL    requested control symbol code
//   CTRL_ACK    one-cycle pulse, request consumed
//   CTRL_ERR    one-cycle pulse with CTRL_ACK for an illegal CTRL_SEL
//   OUT         registered symbols, one byte per lane
//   K_OUT       per-lane K-character flag
//   VALID       sticky, set when the first COM is registered onto OUT
// ----------------------------------------------------------------------------
module tx_symbol_mux_ml
    import tx_sym_pkg::*;
#(
    parameter int unsigned LANES        = 1,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned SKP_COUNT    = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [8*LANES-1:0]   DATA_IN,
    input  logic                 DATA_PUSH,
    output logic                 FIFO_FULL,
    output logic                 FIFO_EMPTY,
    output logic                 OVERFLOW,
    input  logic                 CTRL_REQ,
    input  logic [3:0]           CTRL_SEL,
    output logic                 CTRL_ACK,
    output logic                 CTRL_ERR,
    output logic [8*LANES-1:0]   OUT,
    output logic [LANES-1:0]     K_OUT,
    output logic                 VALID
);

    // Elaboration-time parameter legality checks.
    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("tx_symbol_mux_ml: LANES must be 1..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tx_symbol_mux_ml: DEPTH must be a power of two >= 2");
    end
    if (SKP_COUNT < 1 || SKP_COUNT > 5 || SKP_INTERVAL < SKP_COUNT + 2) begin : g_bad_skp
        $error("tx_symbol_mux_ml: illegal SKP_COUNT / SKP_INTERVAL");
    end

    localparam int unsigned W = 8 * LANES;

    state_e           state_q, state_d;
    logic [W-1:0]     out_q, out_d;
    logic [LANES-1:0] k_q, k_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;

    logic             fifo_pop;
    logic [W-1:0]     fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_overflow;

    // ------------------------------------------------------------------------
    // Data FIFO
    // ------------------------------------------------------------------------
    tx_sym_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .push_i     (DATA_PUSH),
        .wdata_i    (DATA_IN),
        .pop_i      (fifo_pop),
        .rdata_o    (fifo_rdata),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_overflow)
    );

    // The FSM decision of this cycle is what gets registered onto OUT.
    assign fifo_pop = (state_d == StData);

`ifdef SKP_INSERT_EN
    // ------------------------------------------------------------------------
    // Skip counter and ordered-set position
    // ------------------------------------------------------------------------
    localparam int unsigned      CntW    = $clog2(SKP_INTERVAL);
    localparam logic [CntW-1:0]  CntLast = CntW'(SKP_INTERVAL - 1);
    localparam logic [2:0]       SymLast = 3'(SKP_COUNT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      sym_cnt_q, sym_cnt_d;
    logic            skp_due;
    logic            in_set;

    assign skp_due = (cnt_q == CntLast);
    // Still inside an ordered set: after the COM, or before the last SKP.
    assign in_set  = (state_q == StSkpCom) ||
                     ((state_q == StSkpSym) && (sym_cnt_q != SymLast));

    always_comb begin
        if (state_d == StSkpCom) begin
            cnt_d = '0;
        end else if (skp_due) begin
            // Saturate until the pending set can start.
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        sym_cnt_d = (state_q == StSkpSym) ? sym_cnt_q + 3'd1 : 3'd0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q     <= '0;
            sym_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state decision
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = StIdle;
        if (CTRL_REQ) begin
            state_d = StCtrl;
        end else if (!fifo_empty) begin
            state_d = StData;
        end
`ifdef SKP_INSERT_EN
        // An ordered set, running or due, overrides requests and data.
        if (in_set) begin
            state_d = StSkpSym;
        end else if (skp_due) begin
            state_d = StSkpCom;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // FSM: outputs for the decided state (registered below)
    // ------------------------------------------------------------------------
    always_comb begin
        out_d = {LANES{SymIdl}};
        k_d   = '1;
        ack_d = 1'b0;
        err_d = 1'b0;
        unique case (state_d)
            StIdle: ;
            StData: begin
                out_d = fifo_rdata;
                k_d   = '0;
            end
            StCtrl: begin
                out_d = {LANES{ctrl_symbol(CTRL_SEL)}};
                ack_d = 1'b1;
                err_d = (CTRL_SEL > SelMax);
            end
            StSkpCom: out_d = {LANES{SymCom}};
            StSkpSym: out_d = {LANES{SymSkp}};
            default: ;
        endcase
        valid_d = valid_q | (state_d == StSkpCom) |
                  ((state_d == StCtrl) && (CTRL_SEL == SelCom));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_q   <= '0;
            k_q     <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            k_q     <= k_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign OUT        = out_q;
    assign K_OUT      = k_q;
    assign CTRL_ACK   = ack_q;
    assign CTRL_ERR   = err_q;
    assign VALID      = valid_q;
    assign FIFO_FULL  = fifo_full;
    assign FIFO_EMPTY = fifo_empty;
    assign OVERFLOW   = fifo_overflow;

endmodule

// File: tb/tb_tx_symbol_mux_ml.sv
// ----------------------------------------------------------------------------
// tb_tx_symbol_mux_ml
//   Self-checking bench for tx_symbol_mux_ml (LANES=2, DEPTH=4). A queue-based
//   reference model predicts every output each cycle. SKP ordered-set scenarios
//   are included when SKP_INSERT_EN is defined.
// ----------------------------------------------------------------------------
module tb_tx_symbol_mux_ml;

    localparam int LANES        = 2;
    localparam int DEPTH        = 4;
    localparam int SKP_INTERVAL = 10;
    localparam int SKP_COUNT    = 3;
`ifdef SKP_INSERT_EN
    localparam int LAT_MAX = SKP_COUNT + 2;
`else
    localparam int LAT_MAX = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic        req = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  sel = '0;

    logic [15:0] out;
    logic [1:0]  k_out;
    logic        full, empty, ovf, ack, err, valid;

    int checks = 0;
    int errors = 0;

    tx_symbol_mux_ml #(
        .LANES        (LANES),
        .DEPTH        (DEPTH),
        .SKP_INTERVAL (SKP_INTERVAL),
        .SKP_COUNT    (SKP_COUNT)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .DATA_IN    (din),
        .DATA_PUSH  (push),
        .FIFO_FULL  (full),
        .FIFO_EMPTY (empty),
        .OVERFLOW   (ovf),
        .CTRL_REQ   (req),
        .CTRL_SEL   (sel),
        .CTRL_ACK   (ack),
        .CTRL_ERR   (err),
        .OUT        (out),
        .K_OUT      (k_out),
        .VALID      (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model: FIFO as a queue, ordered set as a countdown.
    // ------------------------------------------------------------------------
    logic [7:0]  sym_tbl [9] = '{8'hBC, 8'hF7, 8'h1C, 8'hFB, 8'h5C,
                                 8'hFD, 8'hFE, 8'h3C, 8'h7C};
    logic [15:0] mq [$];
    int          m_cnt = 0;
    int          m_set_left = 0;
    logic        m_ovf = 1'b0;
    logic        m_valid = 1'b0;
    logic [15:0] e_out = '0;
    logic [1:0]  e_k = '0;
    logic        e_ack = 1'b0;
    logic        e_err = 1'b0;

    task automatic model_normal();
        if (req) begin
            e_ack = 1'b1;
            e_k   = 2'b11;
            if (sel > 4'd8) begin
                e_err = 1'b1;
                e_out = 16'h7C7C;
            end else begin
                e_out = {2{sym_tbl[sel]}};
                if (sel == 4'd0) m_valid = 1'b1;
            end
        end else if (mq.size() > 0) begin
            e_out = mq.pop_front();
            e_k   = 2'b00;
        end else begin
            e_out = 16'h7C7C;
            e_k   = 2'b11;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            mq.delete();
            m_cnt = 0; m_set_left = 0; m_ovf = 1'b0; m_valid = 1'b0;
            e_out = '0; e_k = '0; e_ack = 1'b0; e_err = 1'b0;
            return;
        end
        e_ack = 1'b0;
        e_err = 1'b0;
`ifdef SKP_INSERT_EN
        if (m_set_left > 0) begin
            e_out = 16'h1C1C; e_k = 2'b11; m_set_left--;
            if (m_cnt < SKP_INTERVAL - 1) m_cnt++;
        end else if (m_cnt == SKP_INTERVAL - 1) begin
            e_out = 16'hBCBC; e_k = 2'b11; m_valid = 1'b1;
            m_set_left = SKP_COUNT; m_cnt = 0;
        end else begin
            model_normal();
            m_cnt++;
        end
`else
        model_normal();
`endif
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(din);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic [23:0] dut_vec();
        return {out, k_out, ack, err, valid, ovf, full, empty};
    endfunction

    function automatic logic [23:0] exp_vec();
        return {e_out, e_k, e_ack, e_err, m_valid, m_ovf,
                mq.size() == DEPTH, mq.size() == 0};
    endfunction

    // Advance one clock: the model consumes the inputs present at the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({out, k_out, valid, ack, err, ovf, empty, full} !==
            {16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got out=%h k=%b v=%b ack=%b err=%b ovf=%b emp=%b full=%b",
                     out, k_out, valid, ack, err, ovf, empty, full);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out, k_out, valid} !== {16'h7C7C, 2'b11, 1'b0}) begin
                errors++;
                $display("FAIL idle_after_reset: got out=%h k=%b v=%b, want 7c7c 11 0",
                         out, k_out, valid);
            end
        end
    endtask

    task automatic test_ctrl_com();
        req = 1'b1; sel = 4'd0;
        tick();
        checks++;
        if ({out, k_out, ack, valid} !== {16'hBCBC, 2'b11, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ctrl_com: got out=%h k=%b ack=%b v=%b, want bcbc 11 1 1",
                     out, k_out, ack, valid);
        end
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || valid !== 1'b1 || ack !== 1'b0) begin
                errors++;
                $display("FAIL valid_sticky: got %h want %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] got [$];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 1'b1; sel = 4'd1;
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; din = 16'h0100 + 16'(i);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fill_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        push = 1'b0;
        checks++;
        if ({full, ovf} !== 2'b11) begin
            errors++;
            $display("FAIL overflow_flags: got full=%b ovf=%b, want 1 1", full, ovf);
        end
        req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (k_out === 2'b00) got.push_back(out);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (got.size() != 4 || got[0] !== 16'h0100 || got[1] !== 16'h0101 ||
            got[2] !== 16'h0102 || got[3] !== 16'h0103) begin
            errors++;
            $display("FAIL drain_order: got %0d words, first=%h, want 0100..0103",
                     got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
        end
    endtask

    task automatic test_ctrl_err();
        int n = 0;
        req = 1'b1; sel = 4'd12;
        do begin
            tick();
            n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ctrl_err_cycle: got %h want %h", dut_vec(), exp_vec());
            end
        end while (ack !== 1'b1 && n < LAT_MAX + 1);
        checks++;
        if ({ack, err, out, k_out} !== {1'b1, 1'b1, 16'h7C7C, 2'b11}) begin
            errors++;
            $display("FAIL ctrl_err: got ack=%b err=%b out=%h k=%b, want 1 1 7c7c 11",
                     ack, err, out, k_out);
        end
        req = 1'b0;
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 1'b1; sel = 4'd8;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; din = 16'h2000 + 16'(i);
            tick();
        end
        req = 1'b0; din = 16'h2004;
        tick();
        push = 1'b0;
        checks++;
        if ({out, k_out, full, ovf} !== {16'h2000, 2'b00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL push_pop_full: got out=%h k=%b full=%b ovf=%b, want 2000 00 1 0",
                     out, k_out, full, ovf);
        end
        // Streaming: one push per cycle flows straight through.
        for (int i = 0; i < 10; i++) begin
            push = (i >= 4); din = 16'h3000 + 16'(i);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stream_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        push = 1'b0;
    endtask

    task automatic test_random();
        int pend = 0;
        for (int i = 0; i < 400; i++) begin
            if (req && ack) begin
                req = 1'b0;
            end else if (!req && $urandom_range(0, 3) == 0) begin
                req = 1'b1; sel = 4'($urandom_range(0, 11)); pend = 0;
            end
            push = 1'($urandom_range(0, 1));
            din  = 16'($urandom);
            rst  = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (req) begin
                pend++;
                if (rst) begin
                    pend = 0;
                end else if (ack) begin
                    checks++;
                    if (pend > LAT_MAX) begin
                        errors++;
                        $display("FAIL ack_latency: got %0d cycles, want <= %0d", pend, LAT_MAX);
                    end
                end
            end
        end
        rst = 1'b0; req = 1'b0; push = 1'b0;
        tick();
    endtask

`ifdef SKP_INSERT_EN
    task automatic wait_com(input string name);
        int n = 0;
        while (!(out === 16'hBCBC && k_out === 2'b11) && n < 2 * SKP_INTERVAL) begin
            tick();
            n++;
        end
        checks++;
        if (!(out === 16'hBCBC && k_out === 2'b11)) begin
            errors++;
            $display("FAIL %s: no COM within %0d cycles, out=%h", name, n, out);
        end
    endtask

    task automatic test_skp_cadence();
        int coms [$];
        logic [15:0] nxt = 16'h1000;
        logic [15:0] last = '0;
        bit have_last = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 45; i++) begin
            push = !full; din = nxt;
            if (!full) nxt++;
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL skp_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (out === 16'hBCBC && k_out === 2'b11) coms.push_back(i);
            if (k_out === 2'b00) begin
                checks++;
                if (have_last && out !== last + 16'd1) begin
                    errors++;
                    $display("FAIL data_continuity: got %h want %h", out, last + 16'd1);
                end
                last = out; have_last = 1'b1;
            end
        end
        push = 1'b0;
        checks++;
        if (coms.size() < 4 || coms[1] - coms[0] != SKP_INTERVAL ||
            coms[2] - coms[1] != SKP_INTERVAL || coms[3] - coms[2] != SKP_INTERVAL) begin
            errors++;
            $display("FAIL skp_interval: got %0d COMs, want spacing %0d", coms.size(),
                     SKP_INTERVAL);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL skp_no_loss: got ovf=%b want 0", ovf);
        end
    endtask

    task automatic test_skp_ctrl_wait();
        int n = 0;
        wait_com("ctrl_wait_com");
        tick();
        req = 1'b1; sel = 4'd12;
        while (ack !== 1'b1 && n < 10) begin
            tick();
            n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL skp_wait_cycle: got %h want %h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (n != SKP_COUNT || {ack, err, out} !== {1'b1, 1'b1, 16'h7C7C}) begin
            errors++;
            $display("FAIL ack_after_set: got %0d cycles ack=%b err=%b out=%h, want %0d 1 1 7c7c",
                     n, ack, err, out, SKP_COUNT);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_skp_reset();
        wait_com("reset_com");
        tick();
        rst = 1'b1; req = 1'b1; sel = 4'd3;
        tick();
        checks++;
        if ({out, k_out, valid, ack, err, ovf, empty, full} !==
            {16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_set: got out=%h k=%b v=%b ack=%b", out, k_out, valid, ack);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({ack, out, k_out} !== {1'b1, 16'hFBFB, 2'b11}) begin
            errors++;
            $display("FAIL served_after_reset: got ack=%b out=%h k=%b, want 1 fbfb 11",
                     ack, out, k_out);
        end
        req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_ctrl_com();
        test_overflow();
        test_ctrl_err();
        test_back_to_back();
        test_random();
`ifdef SKP_INSERT_EN
        test_skp_cadence();
        test_skp_ctrl_wait();
        test_skp_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
